pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program counter and instruction-fetch front end. It owns the word-indexed PC and issues single-outstanding requests to instruction memory.
- Fetched instructions go downstream with a valid/ready handshake, together with their PC and PC+1.
- It consumes the branch target computed from PC+1 (the redirect input) and so closes the loop of the branch-target path.
- PC unit is one word; PC+1 is the sequential successor.

Parameters:
- WIDTH, 32, width of PC, addresses and instruction word.
- RESET_PC, 0, PC value loaded at reset (word index).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- redirect_valid  input  1  taken branch/jump this cycle.
- redirect_pc  input  WIDTH  new PC (branch target, word index).
- imem_req  output  1  fetch request valid.
- imem_addr  output  WIDTH  word address of request.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response data valid (at least 1 cycle after gnt).
- imem_rdata  input  WIDTH  response instruction.
- if_valid  output  1  buffered instruction available.
- if_ready  input  1  downstream accepts instruction.
- if_instr  output  WIDTH  buffered instruction.
- if_pc  output  WIDTH  PC of buffered instruction.
- if_pcp1  output  WIDTH  if_pc + 1, feeds the branch-target adder.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; state=BOOT; kill=0; imem_req=0; imem_addr=RESET_PC; if_valid=0; if_instr=0; if_pc=0; if_pcp1=0.
- Arithmetic: pc+1 and if_pcp1 wrap modulo 2^WIDTH; 2^WIDTH-1 + 1 = 0. No sign handling.
- State BOOT: one idle cycle after reset release, then go to REQ.
- State REQ:
  - imem_req=1 and imem_addr=pc, both registered outputs.
  - On imem_gnt, go to WAIT, recording the issued address in req_pc.
  - Before grant, imem_addr may change only on redirect.
- State WAIT:
  - imem_req=0.
  - On imem_rvalid with kill=0: if_instr=imem_rdata, if_pc=req_pc, if_pcp1=req_pc+1, if_valid=1, pc=req_pc+1, go to HOLD.
  - On imem_rvalid with kill=1: discard the data, clear kill, go to REQ.
- State HOLD:
  - if_valid=1 and outputs are stable.
  - On if_ready: if_valid=0 next cycle, go to REQ.
  - Minimum issue interval is 3 cycles per instruction (REQ, WAIT, HOLD), with zero-wait gnt and rvalid one cycle after gnt.
- Redirect, accepted in any state except BOOT, and takes priority over all other events in the same cycle:
  - REQ, no gnt: pc=redirect_pc and imem_addr=redirect_pc next cycle; stay in REQ.
  - REQ with gnt the same cycle: pc=redirect_pc, kill=1, go to WAIT.
  - WAIT: pc=redirect_pc and kill=1. If rvalid arrives in the same cycle, discard the data, kill stays 0, go to REQ.
  - HOLD: drop the buffered instruction (if_valid=0 next cycle) even if if_ready=1 that cycle (no handshake counted); pc=redirect_pc; go to REQ.
  - Redirect in BOOT is ignored.
- At most one request is outstanding. imem_rvalid outside WAIT is ignored.
- if_valid never falls without if_ready, except on a redirect.
- Reset mid-transaction returns to BOOT immediately. A late rvalid after reset is ignored because the state is not WAIT.

Optional Feature:
- Macro FETCH_CNT_EN.
- Defined: adds output port fetch_count (32 bits), reset to 0. It increments by 1 on every cycle with if_valid && if_ready && !redirect_valid, and wraps at 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, gnt always 1, rvalid 1 cycle after gnt, if_ready=1, memory[i]=i+0x100 -> imem_addr 0,1,2 on successive REQ cycles; if_instr 0x100,0x101,0x102; if_pcp1 1,2,3.
- Redirect to 0x40 while in HOLD with if_pc=5 -> if_valid drops without a handshake; next imem_addr=0x40; the next delivered instruction has if_pc=0x40 and if_pcp1=0x41.
- Redirect to 0x80 while in WAIT (rvalid delayed 3 cycles) -> stale response discarded, if_valid stays 0; next request at 0x80.
- gnt held 0 for 4 cycles, redirect to 0x10 on cycle 2 -> imem_addr changes to 0x10 and req stays high until gnt.
- RESET_PC=32'hFFFFFFFF -> first if_pc=FFFFFFFF, if_pcp1=0, next imem_addr=0.
- if_ready held 0 for 5 cycles in HOLD -> if_valid, if_instr and if_pc stable, imem_req=0. With FETCH_CNT_EN defined, fetch_count increments only on the accepting cycle.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch front end.
// Holds the word-indexed PC, issues requests to instruction memory, buffers one
// instruction for a valid/ready consumer and accepts branch redirects.
// Optional: define FETCH_CNT_EN to add the fetch_count accepted-instruction counter.
module pc_fetch_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_pcp1
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0]      fetch_count
`endif
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] pc, pc_nx;
  logic [WIDTH-1:0] req_pc, req_pc_nx;
  logic [WIDTH-1:0] req_pcp1;
  logic             kill, kill_nx;
  logic             load;
  logic             drop;

  assign req_pcp1 = req_pc + WIDTH'(1);

  // Next-state logic; a redirect outranks grant, response and handshake events.
  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    req_pc_nx = req_pc;
    kill_nx   = kill;
    load      = 1'b0;
    drop      = 1'b0;
    unique case (state)
      BOOT: state_nx = REQ;
      REQ: begin
        if (imem_gnt) begin
          req_pc_nx = imem_addr;
          state_nx  = WAIT;
        end
        if (redirect_valid) begin
          pc_nx = redirect_pc;
          if (imem_gnt) kill_nx = 1'b1;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_nx = redirect_pc;
          if (imem_rvalid) begin
            kill_nx  = 1'b0;
            state_nx = REQ;
          end else begin
            kill_nx = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill) begin
            kill_nx  = 1'b0;
            state_nx = REQ;
          end else begin
            load     = 1'b1;
            pc_nx    = req_pcp1;
            state_nx = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          drop     = 1'b1;
          pc_nx    = redirect_pc;
          state_nx = REQ;
        end else if (if_ready) begin
          drop     = 1'b1;
          state_nx = REQ;
        end
      end
      default: state_nx = BOOT;
    endcase
  end

  // Control state, PC and in-flight request bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BOOT;
      pc     <= RESET_PC;
      req_pc <= '0;
      kill   <= 1'b0;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      req_pc <= req_pc_nx;
      kill   <= kill_nx;
    end
  end

  // Registered memory request and fetch buffer; imem_addr tracks the next PC so
  // it only moves during REQ on a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      if_valid  <= 1'b0;
      if_instr  <= '0;
      if_pc     <= '0;
      if_pcp1   <= '0;
    end else begin
      imem_req  <= (state_nx == REQ);
      imem_addr <= pc_nx;
      if (load) begin
        if_valid <= 1'b1;
        if_instr <= imem_rdata;
        if_pc    <= req_pc;
        if_pcp1  <= req_pcp1;
      end else if (drop) begin
        if_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_CNT_EN
  // Count instructions accepted downstream; a redirect cancels the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_count <= '0;
    else if (if_valid && if_ready && !redirect_valid) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule
